usb_fifo_if: RTL
================

// Module: usb_fifo_if
// PURPOSE
//  Host-side byte link to the FT-series USB FIFO in async 245 mode; the stage between the fifo_* pins and command logic.
//  Handshakes RXF#/RD# to pull host bytes into a small RX buffer, and TXE#/WR# to push device bytes out.
//  Exposes valid/ready byte streams; the top level owns the fifo_d tristate pad via fifo_d_out/fifo_d_oe.
// PARAMETERS
//  RD_PULSE     3  cycles fifo_rd_n held low per read (>=2)
//  WR_PULSE     3  cycles fifo_wr_n held low per write (>=1)
//  RECOVER      4  idle cycles after any transfer before re-sampling flags (>=3, covers synchroniser lag)
//  RX_DEPTH     4  RX buffer entries, power of two, >=2
//  SIWU_IDLE   64  idle cycles after last write before SIWU pulse (macro build only)
// PORTS
//  clock        in   1  system clock, all logic rising-edge
//  reset        in   1  asynchronous, active-high
//  fifo_d_in    in   8  pad data from FIFO chip
//  fifo_d_out   out  8  pad data to FIFO chip
//  fifo_d_oe    out  1  1 = drive fifo_d
//  fifo_rxf_n   in   1  low = chip has a byte for us (async)
//  fifo_txe_n   in   1  low = chip can accept a byte (async)
//  fifo_rd_n    out  1  read strobe, active low
//  fifo_wr_n    out  1  write strobe, active low
//  fifo_siwu    out  1  send-immediate/wakeup, active low
//  rx_data      out  8  received byte, head of RX buffer
//  rx_valid     out  1  rx_data valid
//  rx_ready     in   1  consumer takes byte when rx_valid&rx_ready
//  tx_data      in   8  byte to send
//  tx_valid     in   1  tx_data valid
//  tx_ready     out  1  holding register empty; byte taken when tx_valid&tx_ready
// BEHAVIOUR
//  Reset: fifo_rd_n=1, fifo_wr_n=1, fifo_siwu=1, fifo_d_oe=0, fifo_d_out=0, rx_valid=0, tx_ready=1, state IDLE, RX buffer empty, last_served=WRITE.
//  fifo_rxf_n/fifo_txe_n pass 2-flop synchronisers (reset to 1); FSM sees only synchronised values.
//  FSM: IDLE, RD_LOW, WR_SETUP, WR_LOW, WR_HOLD, RECOVER.
//  IDLE: rd_ok = rxf_s==0 && buffer not full; wr_ok = txe_s==0 && holding full.
//   Both ok -> serve opposite of last_served; one ok -> serve it; none -> stay.
//  RD_LOW: rd_n=0 for RD_PULSE cycles; fifo_d_in sampled on last low cycle, written into buffer on rd_n rising edge -> RECOVER.
//  WR_SETUP (1 cycle): d_oe=1, d_out=holding, wr_n=1. WR_LOW: wr_n=0 for WR_PULSE cycles.
//  WR_HOLD (1 cycle): wr_n=1, d_oe=1, d_out stable; holding cleared (tx_ready=1 next cycle) -> RECOVER.
//  RECOVER: all strobes high, d_oe=0 for RECOVER cycles -> IDLE. d_oe never 1 while rd_n=0.
//  RX buffer: registered-output FIFO; rx_valid rises 1 cycle after write into empty buffer; simultaneous push+pop when full is impossible (full blocks reads).
//  Pointers log2(RX_DEPTH)+1 bits, wrap naturally; full = MSB differ, rest equal.
//  tx_ready=1 whenever holding empty, including while a read is in flight.
//  Reset mid-transfer: strobes return high and d_oe drops asynchronously; partial byte discarded.
// CONFIGURATION
//  USB_FIFO_SIWU_EN defined: counter counts idle cycles since last WR_HOLD while holding empty;
//   at SIWU_IDLE, drive fifo_siwu=0 for WR_PULSE cycles, once per burst; any new tx_valid restarts counter.
//   Pulse is held off while FSM is not IDLE.
//  Undefined: fifo_siwu tied 1, no counter logic.
// STRUCTURE
//  Shared package/header usb_fifo_defs: FSM state encoding, RD_PULSE/WR_PULSE/RECOVER defaults, width of pulse counter.
//  One sub-module: byte_fifo (parameter DEPTH, 8-bit, registered output) for the RX buffer.
//  Synchronisers and FSM stay inline.
// TESTING
//  Host model holds rxf_n low with bytes 0x11,0x22,0x33, rx_ready=1 -> rd_n low exactly 3 cycles each, rx_data 0x11,0x22,0x33 in order.
//  rx_ready=0, 6 host bytes pending -> exactly 4 reads, then rd_n stays 1 until a pop; 5th byte follows after pop.
//  tx_valid with 0xA5, txe_n=0 -> wr_n low 3 cycles, fifo_d_out=0xA5 and d_oe=1 from 1 cycle before to 1 cycle after; tx_ready high again next cycle.
//  rxf_n=0 and txe_n=0 with tx continuously valid -> strobes alternate read, write, read, write; no d_oe overlap with rd_n=0.
//  reset asserted during RD_LOW cycle 2 -> rd_n=1 and d_oe=0 same cycle, rx_valid=0, no byte enters buffer.
//  USB_FIFO_SIWU_EN, single write then idle -> fifo_siwu low 3 cycles starting 64 cycles after WR_HOLD, once; none if tx_valid in between.

Source files
------------

// File: rtl/usb_fifo_defs_pkg.sv
// Shared definitions for the FT-series async-245 FIFO link: FSM states,
// default strobe/recovery timings and the width of the strobe pulse counter.
package usb_fifo_defs;

  localparam int RD_PULSE_DEF  = 3;
  localparam int WR_PULSE_DEF  = 3;
  localparam int RECOVER_DEF   = 4;
  localparam int RX_DEPTH_DEF  = 4;
  localparam int SIWU_IDLE_DEF = 64;

  localparam int PCNT_W = 4;
  typedef logic [PCNT_W-1:0] pcnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LOW,
    ST_WR_SETUP,
    ST_WR_LOW,
    ST_WR_HOLD,
    ST_RECOVER
  } state_t;

  typedef enum logic {
    SRV_READ,
    SRV_WRITE
  } served_t;

  // Counters run down to zero, so an N-cycle phase loads N-1.
  function automatic pcnt_t pulse_load(input int cycles);
    return pcnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/usb_fifo_if_byte_fifo.sv
// Small 8-bit FIFO with a registered output stage, used as the RX buffer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] rd_ptr_next;
  logic        pop;

  assign pop         = out_valid && out_ready;
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  always_ff @(posedge clock) begin
    if (push && !full)
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Head is re-read every cycle from the post-pop pointer; an entry written
  // on this edge becomes visible one cycle later.
  always_ff @(posedge clock) begin
    out_data <= mem[rd_ptr_next[AW-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      out_valid  <= (wr_ptr_reg != rd_ptr_next);
    end
  end

endmodule

// File: rtl/usb_fifo_if.sv
// Host-side byte link to an FT-series USB FIFO in async 245 mode.
// Optional SIWU flush pulse after a write burst goes idle: define USB_FIFO_SIWU_EN.
module usb_fifo_if
  import usb_fifo_defs::*;
#(
  parameter int RD_PULSE  = RD_PULSE_DEF,
  parameter int WR_PULSE  = WR_PULSE_DEF,
  parameter int RECOVER   = RECOVER_DEF,
`ifdef USB_FIFO_SIWU_EN
  parameter int SIWU_IDLE = SIWU_IDLE_DEF,
`endif
  parameter int RX_DEPTH  = RX_DEPTH_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fifo_d_in,
  output logic [7:0] fifo_d_out,
  output logic       fifo_d_oe,
  input  logic       fifo_rxf_n,
  input  logic       fifo_txe_n,
  output logic       fifo_rd_n,
  output logic       fifo_wr_n,
  output logic       fifo_siwu,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  logic    rxf_meta_reg, rxf_s_reg;
  logic    txe_meta_reg, txe_s_reg;
  state_t  state_reg;
  pcnt_t   cnt_reg;
  served_t last_reg;
  logic    rd_n_reg, wr_n_reg, d_oe_reg;
  logic [7:0] d_out_reg;
  logic [7:0] hold_reg;
  logic    hold_full_reg;
  logic    rx_full, rx_push, rd_ok, wr_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxf_meta_reg <= 1'b1;
      rxf_s_reg    <= 1'b1;
      txe_meta_reg <= 1'b1;
      txe_s_reg    <= 1'b1;
    end else begin
      rxf_meta_reg <= fifo_rxf_n;
      rxf_s_reg    <= rxf_meta_reg;
      txe_meta_reg <= fifo_txe_n;
      txe_s_reg    <= txe_meta_reg;
    end
  end

  assign rd_ok   = !rxf_s_reg && !rx_full;
  assign wr_ok   = !txe_s_reg && hold_full_reg;
  // The pad byte is captured on the edge that ends the last low cycle.
  assign rx_push = (state_reg == ST_RD_LOW) && (cnt_reg == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      last_reg      <= SRV_WRITE;
      rd_n_reg      <= 1'b1;
      wr_n_reg      <= 1'b1;
      d_oe_reg      <= 1'b0;
      d_out_reg     <= 8'h00;
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
    end else begin
      if (tx_valid && !hold_full_reg) begin
        hold_reg      <= tx_data;
        hold_full_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          // With both sides ready, alternate so neither direction starves.
          if (rd_ok && (!wr_ok || last_reg == SRV_WRITE)) begin
            state_reg <= ST_RD_LOW;
            rd_n_reg  <= 1'b0;
            cnt_reg   <= pulse_load(RD_PULSE);
            last_reg  <= SRV_READ;
          end else if (wr_ok) begin
            state_reg <= ST_WR_SETUP;
            d_oe_reg  <= 1'b1;
            d_out_reg <= hold_reg;
            last_reg  <= SRV_WRITE;
          end
        end
        ST_RD_LOW: begin
          if (cnt_reg == '0) begin
            rd_n_reg  <= 1'b1;
            state_reg <= ST_RECOVER;
            cnt_reg   <= pulse_load(RECOVER);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_WR_SETUP: begin
          wr_n_reg  <= 1'b0;
          cnt_reg   <= pulse_load(WR_PULSE);
          state_reg <= ST_WR_LOW;
        end
        ST_WR_LOW: begin
          if (cnt_reg == '0) begin
            wr_n_reg  <= 1'b1;
            state_reg <= ST_WR_HOLD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          d_oe_reg      <= 1'b0;
          hold_full_reg <= 1'b0;
          state_reg     <= ST_RECOVER;
          cnt_reg       <= pulse_load(RECOVER);
        end
        ST_RECOVER: begin
          if (cnt_reg == '0)
            state_reg <= ST_IDLE;
          else
            cnt_reg <= cnt_reg - 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rd_n  = rd_n_reg;
  assign fifo_wr_n  = wr_n_reg;
  assign fifo_d_oe  = d_oe_reg;
  assign fifo_d_out = d_out_reg;
  assign tx_ready   = !hold_full_reg;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (fifo_d_in),
    .full      (rx_full),
    .out_data  (rx_data),
    .out_valid (rx_valid),
    .out_ready (rx_ready)
  );

`ifdef USB_FIFO_SIWU_EN
  localparam int IW = $clog2(SIWU_IDLE + 1);

  logic [IW-1:0] idle_cnt_reg;
  logic          siwu_armed_reg;
  logic          siwu_reg;
  pcnt_t         siwu_cnt_reg;

  // Armed by each completed write, fired once when the link stays quiet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt_reg   <= '0;
      siwu_armed_reg <= 1'b0;
      siwu_reg       <= 1'b1;
      siwu_cnt_reg   <= '0;
    end else begin
      if (!siwu_reg) begin
        if (siwu_cnt_reg == '0)
          siwu_reg <= 1'b1;
        else
          siwu_cnt_reg <= siwu_cnt_reg - 1'b1;
      end
      if (state_reg == ST_WR_HOLD) begin
        siwu_armed_reg <= 1'b1;
        idle_cnt_reg   <= '0;
      end else if (tx_valid || hold_full_reg) begin
        idle_cnt_reg <= '0;
      end else if (siwu_armed_reg && idle_cnt_reg != IW'(SIWU_IDLE)) begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end else if (siwu_armed_reg && state_reg == ST_IDLE && siwu_reg) begin
        siwu_reg       <= 1'b0;
        siwu_cnt_reg   <= pulse_load(WR_PULSE);
        siwu_armed_reg <= 1'b0;
      end
    end
  end

  assign fifo_siwu = siwu_reg;
`else
  assign fifo_siwu = 1'b1;
`endif

endmodule
